// File: rtl/con_loader.sv
// Byte-stream loader that writes assembled little-endian 32-bit words into BLOCKMEM
// over the con_* port. Define CON_LOADER_VERIFY_EN to add a readback-compare pass.
module con_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [3:0]        con_write,
  output logic [ADDR_W-1:0] con_addr,
  output logic [31:0]       con_in,
  input  logic [31:0]       con_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_VRD     = 3'd3;
  localparam logic [2:0] S_VCMP    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  // Byte handshake: a byte moves on a rising edge where rx_valid && rx_ready.
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_eff;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_word;

`ifdef CON_LOADER_VERIFY_EN
  logic [CNT_W-1:0]  err_q, err_d;
`else
  logic              unused_con_out;
  assign unused_con_out = ^con_out;
`endif

  // A zero count selects the full memory depth.
  assign count_eff = (word_count == '0) ? CNT_W'(2 ** ADDR_W) : word_count;
  assign wr_addr   = base_q + idx_q[ADDR_W-1:0];
  assign last_word = ((idx_q + CNT_W'(1)) == count_q);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    done_d  = done_q;
`ifdef CON_LOADER_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = count_eff;
          idx_d   = '0;
          bidx_d  = '0;
          done_d  = 1'b0;
`ifdef CON_LOADER_VERIFY_EN
          err_d   = '0;
`endif
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (rx_valid) begin
          word_d[{bidx_q, 3'b000} +: 8] = rx_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
`ifdef CON_LOADER_VERIFY_EN
        state_d = S_VRD;
`else
        idx_d   = idx_q + CNT_W'(1);
        state_d = last_word ? S_FIN : S_COLLECT;
`endif
      end
`ifdef CON_LOADER_VERIFY_EN
      S_VRD: state_d = S_VCMP;
      S_VCMP: begin
        if ((con_out != word_q) && (err_q != '1)) err_d = err_q + CNT_W'(1);
        idx_d   = idx_q + CNT_W'(1);
        state_d = last_word ? S_FIN : S_COLLECT;
      end
`endif
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
`ifdef CON_LOADER_VERIFY_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      done_q  <= done_d;
`ifdef CON_LOADER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decode from registered state so reset forces them low at once.
  always_comb begin
    rx_ready  = (state_q == S_COLLECT);
    con_write = (state_q == S_WRITE) ? 4'hF : 4'h0;
    con_in    = (state_q == S_WRITE) ? word_q : 32'h0;
    con_addr  = '0;
    if ((state_q == S_WRITE) || (state_q == S_VRD) || (state_q == S_VCMP)) con_addr = wr_addr;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;
`ifdef CON_LOADER_VERIFY_EN
  assign err_cnt   = err_q;
`else
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_con_loader.sv
// Directed bench for con_loader: BLOCKMEM model, write monitor and scoreboard.
module tb_con_loader;

  localparam int ADDR_W = 10;
  localparam int CNT_W  = 11;
`ifdef CON_LOADER_VERIFY_EN
  localparam int CYC_PER_WORD = 7;
  localparam int VERIFY_ON    = 1;
`else
  localparam int CYC_PER_WORD = 5;
  localparam int VERIFY_ON    = 0;
`endif

  logic              CLK = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [3:0]        con_write;
  logic [ADDR_W-1:0] con_addr;
  logic [31:0]       con_in;
  logic [31:0]       con_out = '0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_cnt;
  logic [2:0]        dbg_state;

  con_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nrst(nrst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .con_write(con_write), .con_addr(con_addr),
    .con_in(con_in), .con_out(con_out), .busy(busy), .done(done),
    .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int bad_we = 0;
  logic [41:0] exp_q[$];
  logic [41:0] obs_q[$];
  logic [31:0] mem [0:1023];
  logic        corrupt_en = 1'b0;
  logic [9:0]  corrupt_addr = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // BLOCKMEM model: byte-enabled write, one-cycle synchronous read.
  always @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
    con_out <= mem[con_addr] ^ {31'b0, (corrupt_en && con_addr == corrupt_addr)};
  end

  always @(negedge CLK) begin
    if (con_write != 4'h0) begin
      obs_q.push_back({con_addr, con_in});
      if (con_write != 4'hF) bad_we++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  // All driver tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check_val("rx_ready_timeout", 64'(n), 64'd0);
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("start_done_clr", done, 0);
    check_val("start_rx_ready", rx_ready, 1);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check_val("done_seen", done, 1);
    check_val("done_idle", busy, 0);
  endtask

  task automatic check_writes(input string tag);
    check_val({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check_val(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n_cyc;
    clear_mem();
    // Reset state
    repeat (3) @(negedge CLK);
    check_val("rst_con_write", con_write, 0);
    check_val("rst_con_addr", con_addr, 0);
    check_val("rst_con_in", con_in, 0);
    check_val("rst_rx_ready", rx_ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err_cnt, 0);
    check_val("rst_state", dbg_state, 0);
    nrst = 1'b1;
    @(negedge CLK);

    // Reset asserted during the write of word 1
    start_load(10'h000, 11'd2);
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    check_val("midrst_pre_we", con_write, 4'hF);
    check_val("midrst_pre_addr", con_addr, 10'h001);
    nrst = 1'b0;
    #1;
    check_val("midrst_we", con_write, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_err", err_cnt, 0);
    check_val("midrst_rx_ready", rx_ready, 0);
    @(negedge CLK);
    nrst = 1'b1;
    @(negedge CLK);
    obs_q.delete();
    clear_mem();

    // Basic load, back-to-back bytes, with done latency
    start_load(10'h000, 11'd2);
    exp_q.push_back({10'h000, 32'h1234_5678});
    exp_q.push_back({10'h001, 32'hDEAD_BEEF});
    fork
      wait_done(200, n_cyc);
      begin
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 0);
      end
    join
    check_val("basic_done_cycles", 64'(n_cyc), 64'(2 * CYC_PER_WORD + 1));
    check_writes("basic_wr");
    check_val("basic_mem0", mem[0], 32'h1234_5678);
    check_val("basic_mem1", mem[1], 32'hDEAD_BEEF);
    check_val("basic_err", err_cnt, 0);
    repeat (3) @(negedge CLK);
    check_val("done_held", done, 1);

    // Throttled source: rx_valid every third cycle
    clear_mem();
    start_load(10'h000, 11'd2);
    exp_q.push_back({10'h000, 32'h1234_5678});
    exp_q.push_back({10'h001, 32'hDEAD_BEEF});
    send_word(32'h1234_5678, 2);
    send_word(32'hDEAD_BEEF, 2);
    wait_done(200, n_cyc);
    check_writes("thr_wr");
    check_val("thr_mem0", mem[0], 32'h1234_5678);
    check_val("thr_mem1", mem[1], 32'hDEAD_BEEF);

    // Address wrap from the top word
    start_load(10'h3FF, 11'd2);
    exp_q.push_back({10'h3FF, 32'hCAFE_0001});
    exp_q.push_back({10'h000, 32'hCAFE_0002});
    send_word(32'hCAFE_0001, 0);
    send_word(32'hCAFE_0002, 0);
    wait_done(200, n_cyc);
    check_writes("wrap_wr");

    // Readback corruption on the second word
    corrupt_en   = 1'b1;
    corrupt_addr = 10'h001;
    start_load(10'h000, 11'd2);
    exp_q.push_back({10'h000, 32'h0BAD_F00D});
    exp_q.push_back({10'h001, 32'h5555_AAAA});
    send_word(32'h0BAD_F00D, 0);
    send_byte(8'hAA, 0);
    check_val("vfy_err_word0", err_cnt, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'h55, 0);
    wait_done(200, n_cyc);
    check_val("vfy_err_final", err_cnt, 64'(VERIFY_ON));
    check_writes("vfy_wr");
    corrupt_en = 1'b0;

    // Start while busy is ignored; count 0 loads the full depth
    start_load(10'h200, 11'd0);
    for (int i = 0; i < 1024; i++)
      exp_q.push_back({10'(10'h200 + i), 32'hA500_0000 | 32'(i)});
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    base_addr  = 10'h100;
    word_count = 11'd5;
    start      = 1'b1;
    send_byte(8'h00, 0);
    start = 1'b0;
    send_byte(8'hA5, 0);
    for (int i = 1; i < 1024; i++) send_word(32'hA500_0000 | 32'(i), 0);
    wait_done(200, n_cyc);
    check_val("full_mem_first", mem[10'h200], 32'hA500_0000);
    check_val("full_mem_last", mem[10'h1FF], 32'hA500_03FF);
    check_writes("full_wr");

    check_val("we_mask", 64'(bad_we), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/con_loader.md
# con_loader

Hardware loader that drives the core's console memory port (`con_write`/`con_addr`/`con_in`/`con_out`) as an initiator, writing a stream of bytes into BLOCKMEM as 32-bit words. It is the write-side counterpart of the bench readback path. It sits between a byte source (e.g. a UART receiver) and the core's `con_*` inputs, so test images and answer data can be preloaded without simulation-only memory init. An optional readback-verify pass checks each written word.

## Interface
- `ADDR_W`, 10: word address width; memory depth is 2^ADDR_W words.
- `CNT_W`, 11: width of `word_count` and `err_cnt`.

Ports:
- `CLK`  in  1  clock; single clock domain.
- `nrst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a load; ignored while `busy`.
- `base_addr`  in  ADDR_W  first word address; sampled on accepted `start`.
- `word_count`  in  CNT_W  number of words; sampled on accepted `start`; 0 means 2^ADDR_W.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `con_write`  out  4  byte write enables to BLOCKMEM.
- `con_addr`  out  ADDR_W  word address to BLOCKMEM.
- `con_in`  out  32  write data to BLOCKMEM.
- `con_out`  in  32  BLOCKMEM read data; one-cycle synchronous read latency.
- `busy`  out  1  load in progress.
- `done`  out  1  last load finished; held until the next accepted `start`.
- `err_cnt`  out  CNT_W  verify mismatch count; saturates at all-ones.

## Operation
- States: IDLE, COLLECT, WRITE, VRD, VCMP, FIN.
  - VRD and VCMP exist only with verify compiled in.
- IDLE:
  - Outputs: `con_write`=0, `con_addr`=0, `con_in`=0, `rx_ready`=0.
  - On `start`: latch base and count, clear word index, byte index and `err_cnt`, clear `done`, then go to COLLECT.
- COLLECT:
  - `rx_ready`=1.
  - Each `rx_valid && rx_ready` stores the byte little-endian: byte k goes to word[8k+7:8k], k=0..3.
  - After the 4th byte is accepted, go to WRITE.
- WRITE (one cycle):
  - `con_write`=4'hF, `con_addr`=(base+idx) mod 2^ADDR_W, `con_in`=assembled word, `rx_ready`=0.
  - Next state: VRD if verify is built in; otherwise COLLECT, or FIN if this was the last word.
- VRD:
  - `con_write`=0, same `con_addr`.
  - Go to VCMP.
- VCMP:
  - Compare `con_out` with the latched word; on mismatch, `err_cnt`+1 (saturating).
  - Next state: COLLECT, or FIN if this was the last word.
- FIN (one cycle):
  - `con_write`=0, `con_addr`=0.
  - Set `done`, go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; the index counter is CNT_W bits.
- `busy`=1 in every state except IDLE.
- `con_write` is never nonzero outside WRITE. Partial words are never written.

## Timing
- Reset: all outputs 0, state IDLE. Reset takes effect immediately (asynchronously) even mid-WRITE. Collected bytes are discarded.
- `start` to first `rx_ready`=1: 1 cycle.
- Minimum cycles per word with back-to-back bytes: 5 without verify, 7 with verify.
- The last-word write (or compare) is followed by FIN; `done` rises the cycle after FIN.
- `rx_valid` gaps stall COLLECT with no other effect.
- Bytes presented while `rx_ready`=0 are not consumed.
- A `start` coinciding with FIN/`done` is ignored. A `start` in IDLE with `done`=1 restarts.

## Configuration
- `CON_LOADER_VERIFY_EN`
  - Defined: VRD/VCMP states are built in, `err_cnt` counts mismatches, 7 cycles/word minimum.
  - Undefined: WRITE goes straight to COLLECT/FIN, `err_cnt` is tied to 0, 5 cycles/word minimum.

## Test plan
- Reset mid-load:
  - Stimulus: assert `nrst`=0 during the WRITE of word 1.
  - Required: `con_write`=0 immediately; `busy`=0, `done`=0, `err_cnt`=0; a new `start` reloads from the base.
- Basic load:
  - Stimulus: base=0, count=2, bytes 78 56 34 12 EF BE AD DE back-to-back.
  - Required: write 0x12345678 at addr 0x000 and 0xDEADBEEF at addr 0x001, each with `con_write`=4'hF for exactly 1 cycle; `done`=1 after 11 cycles without verify (15 with verify).
- Throttled source:
  - Stimulus: same bytes, `rx_valid` high only every 3rd cycle.
  - Required: identical memory contents and no extra writes.
- Address wrap:
  - Stimulus: base=0x3FF, count=2.
  - Required: writes land at 0x3FF, then 0x000.
- Verify mismatch (`CON_LOADER_VERIFY_EN`):
  - Stimulus: memory model corrupts bit 0 of the 2nd word on readback.
  - Required: `err_cnt`=1; the first word produces no increment.
- Start while busy:
  - Stimulus: pulse `start` with base=0x100 during COLLECT of word 0.
  - Required: ignored; the load continues at the original base; `word_count`=0 loads 1024 words.
